// File: rtl/inst_word_assembler_pkg.sv
// Shared definitions for the instruction word assembler slice.
// Holds the bus widths, the assembler FSM state type, the endianness
// selectors and the byte-lane insertion helper used by the assembler.
package inst_word_assembler_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int PHASE_W = 2;

  localparam bit ENDIAN_BIG    = 1'b1;
  localparam bit ENDIAN_LITTLE = 1'b0;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_e;

  // Big-endian streams fill from the top lane down, so byte N lands in
  // lane 3-N (the bitwise inverse of a 2-bit phase); little-endian uses lane N.
  function automatic logic [WORD_W-1:0] insertByte(
    input logic [WORD_W-1:0]  word,
    input logic [BYTE_W-1:0]  data,
    input logic [PHASE_W-1:0] phase,
    input bit                 bigEndian
  );
    logic [WORD_W-1:0]  result;
    logic [PHASE_W-1:0] lane;
    result = word;
    lane   = bigEndian ? ~phase : phase;
    result[int'(lane)*BYTE_W +: BYTE_W] = data;
    return result;
  endfunction

endpackage

// File: rtl/inst_word_assembler_if.sv
// Byte-in / word-out handshake bundle of the instruction word assembler.
//   rx_data, rx_valid    : byte strobe from the debug UART receiver
//   inst_out, inst_valid : head-of-FIFO instruction word and its valid flag
//   inst_ready           : decoder accepts the head word
// slave  = assembler view, master = feeder/consumer (bench) view.
interface inst_word_assembler_if;
  import inst_word_assembler_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic [WORD_W-1:0] inst_out;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output rx_data, rx_valid, inst_ready,
    input  inst_out, inst_valid
  );

  modport slave (
    input  rx_data, rx_valid, inst_ready,
    output inst_out, inst_valid
  );

endinterface

// File: rtl/inst_word_assembler_fifo.sv
// inst_fifo: synchronous FIFO with synchronous active-high reset.
//   clk, reset : clock and reset
//   push, din  : write request and data (taken when not full, or full with a pop)
//   pop, dout  : read request and head-of-queue data
//   empty, full: occupancy flags
// Storage is cleared on reset so dout is a known value before any push.
module inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign doPop  = pop & ~empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts.
  assign doPush = push & (~full | doPop);
  assign dout   = mem_q[rdPtr_q];

  // Pointers rely on the power-of-two depth to wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= din;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_word_assembler.sv
// inst_word_assembler: packs debug-UART bytes into 32-bit instruction words
// and queues them for the instruction decoder.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : rx byte strobe in, inst word valid/ready out
//   word_count  : words accepted into the FIFO (wraps at 16 bits)
//   byte_phase  : bytes held of the current partial word
//   timeout_err : one-cycle pulse when a stale partial word is dropped
//   overflow    : sticky, a completed word was lost to a full FIFO
module inst_word_assembler
  import inst_word_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_word_assembler_if.slave bus,
  output logic [15:0]          word_count,
  output logic [PHASE_W-1:0]   byte_phase,
  output logic                 timeout_err,
  output logic                 overflow
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  asm_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               timeoutErr_q, timeoutErr_d;
  logic [15:0]        wordCount_q, wordCount_d;
  logic               overflow_q, overflow_d;

  logic [WORD_W-1:0]  merged;
  logic               wordDone;
  logic               pushAccepted;
  logic               fifoPop;
  logic               fifoEmpty;
  logic               fifoFull;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      shift_q      <= '0;
      timer_q      <= '0;
      timeoutErr_q <= 1'b0;
      wordCount_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      timeoutErr_q <= timeoutErr_d;
      wordCount_q  <= wordCount_d;
      overflow_q   <= overflow_d;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the timeout,
  // which is why the rx_valid branch is tested before the timer compare.
  // The completed word goes straight to the FIFO, so the shift register
  // never holds a full word.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    timeoutErr_d = 1'b0;
    wordDone     = 1'b0;
    merged       = insertByte(shift_q, bus.rx_data, phase_q, BIG_ENDIAN == ENDIAN_BIG);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bus.rx_valid) begin
          shift_d = merged;
          phase_d = PHASE_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.rx_valid) begin
          timer_d = '0;
          if (phase_q == PHASE_W'(3)) begin
            wordDone = 1'b1;
            shift_d  = '0;
            phase_d  = '0;
            state_d  = IDLE;
          end else begin
            shift_d = merged;
            phase_d = phase_q + PHASE_W'(1);
          end
        end else if (timer_q == TMR_LAST) begin
          timer_d      = '0;
          shift_d      = '0;
          phase_d      = '0;
          state_d      = IDLE;
          timeoutErr_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifoPop      = ~fifoEmpty & bus.inst_ready;
  assign pushAccepted = wordDone & (~fifoFull | fifoPop);

  always_comb begin
    wordCount_d = wordCount_q;
    overflow_d  = overflow_q;
    if (pushAccepted) begin
      wordCount_d = wordCount_q + 16'd1;
    end
    if (wordDone && fifoFull && !fifoPop) begin
      overflow_d = 1'b1;
    end
  end

  inst_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushAccepted),
    .pop   (fifoPop),
    .din   (merged),
    .dout  (bus.inst_out),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

  assign bus.inst_valid = ~fifoEmpty;
  assign word_count     = wordCount_q;
  assign byte_phase     = phase_q;
  assign timeout_err    = timeoutErr_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_inst_word_assembler.sv
// Testbench for inst_word_assembler: directed scenarios plus a randomized
// run against a queue-based reference model (big-endian DUT), with a second
// little-endian DUT sharing the byte stream for the lane-order check.
module tb_inst_word_assembler;
  import inst_word_assembler_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_word_assembler_if busBe();
  inst_word_assembler_if busLe();

  logic [15:0] wcBe, wcLe;
  logic [1:0]  phBe, phLe;
  logic        toBe, toLe, ovBe, ovLe;

  assign busLe.rx_data    = busBe.rx_data;
  assign busLe.rx_valid   = busBe.rx_valid;
  assign busLe.inst_ready = 1'b1;

  inst_word_assembler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .BIG_ENDIAN(1'b1)) dutBe (
    .clk(clk), .reset(reset), .bus(busBe),
    .word_count(wcBe), .byte_phase(phBe), .timeout_err(toBe), .overflow(ovBe));

  inst_word_assembler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .BIG_ENDIAN(1'b0)) dutLe (
    .clk(clk), .reset(reset), .bus(busLe),
    .word_count(wcLe), .byte_phase(phLe), .timeout_err(toLe), .overflow(ovLe));

  int vectors;
  int miscompares;

  // Reference model: bytes of the word in progress, idle cycles since the
  // last byte, queued words, accepted-word count, sticky overflow, pulse.
  logic [7:0]  mPartial[$];
  logic [31:0] mFifo[$];
  int          mIdle;
  int          mCount;
  bit          mOverflow;
  bit          mTimeoutErr;

  task automatic modelEdge();
    bit          popNow;
    logic [31:0] w;
    mTimeoutErr = 1'b0;
    if (reset) begin
      mPartial.delete(); mFifo.delete();
      mIdle = 0; mCount = 0; mOverflow = 1'b0;
      return;
    end
    popNow = (mFifo.size() != 0) && busBe.inst_ready;
    if (popNow) void'(mFifo.pop_front());
    if (busBe.rx_valid) begin
      mPartial.push_back(busBe.rx_data);
      mIdle = 0;
      if (mPartial.size() == 4) begin
        w = {mPartial[0], mPartial[1], mPartial[2], mPartial[3]};
        mPartial.delete();
        if (mFifo.size() < DEPTH) begin
          mFifo.push_back(w);
          mCount = (mCount + 1) % 65536;
        end else begin
          mOverflow = 1'b1;
        end
      end
    end else if (mPartial.size() != 0) begin
      mIdle++;
      if (mIdle >= TMO) begin
        mPartial.delete();
        mIdle = 0;
        mTimeoutErr = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit rdy);
    busBe.rx_valid   = v;
    busBe.rx_data    = d;
    busBe.inst_ready = rdy;
    tick();
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w, input bit rdy);
    applyStimulus(1'b1, w[31:24], rdy);
    applyStimulus(1'b1, w[23:16], rdy);
    applyStimulus(1'b1, w[15:8],  rdy);
    applyStimulus(1'b1, w[7:0],   rdy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    vectors++; if (busBe.inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", busBe.inst_valid); end
    vectors++; if (busBe.inst_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_inst_out: got %h expected 00000000", busBe.inst_out); end
    vectors++; if ({wcBe, phBe, toBe, ovBe} !== 20'h0) begin miscompares++; $display("[TB] FAIL reset_status: got wc=%h ph=%0d to=%b ov=%b expected all 0", wcBe, phBe, toBe, ovBe); end
    vectors++; if ({busLe.inst_valid, busLe.inst_out, wcLe, phLe, toLe, ovLe} !== 53'h0) begin miscompares++; $display("[TB] FAIL reset_le: got out=%h wc=%h expected all 0", busLe.inst_out, wcLe); end
  endtask

  task automatic test_endianness();
    applyStimulus(1'b1, 8'h24, 1'b1);
    applyStimulus(1'b1, 8'h08, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    vectors++; if (busBe.inst_valid !== 1'b0 || phBe !== 2'd3) begin miscompares++; $display("[TB] FAIL endian_pre: got valid=%b ph=%0d expected 0/3", busBe.inst_valid, phBe); end
    applyStimulus(1'b1, 8'h05, 1'b1);
    vectors++; if (busBe.inst_valid !== 1'b1 || busBe.inst_out !== 32'h24080005) begin miscompares++; $display("[TB] FAIL endian_big: got valid=%b out=%h expected 1/24080005", busBe.inst_valid, busBe.inst_out); end
    vectors++; if (wcBe !== 16'd1 || phBe !== 2'd0) begin miscompares++; $display("[TB] FAIL endian_count: got wc=%0d ph=%0d expected 1/0", wcBe, phBe); end
    vectors++; if (busLe.inst_valid !== 1'b1 || busLe.inst_out !== 32'h05000824 || wcLe !== 16'd1) begin miscompares++; $display("[TB] FAIL endian_little: got valid=%b out=%h wc=%0d expected 1/05000824/1", busLe.inst_valid, busLe.inst_out, wcLe); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    vectors++; if (busBe.inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL endian_pop: got valid=%b expected 0", busBe.inst_valid); end
  endtask

  task automatic test_timeout();
    int pulses;
    int firstAt;
    pulses = 0; firstAt = -1;
    applyStimulus(1'b1, 8'hAA, 1'b1);
    applyStimulus(1'b1, 8'hBB, 1'b1);
    for (int i = 1; i <= TMO + 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (toBe === 1'b1) begin
        pulses++;
        if (firstAt < 0) firstAt = i;
      end
    end
    vectors++; if (pulses != 1 || firstAt != TMO) begin miscompares++; $display("[TB] FAIL timeout_pulse: got %0d pulses first at %0d expected 1 at %0d", pulses, firstAt, TMO); end
    vectors++; if (phBe !== 2'd0) begin miscompares++; $display("[TB] FAIL timeout_phase: got %0d expected 0", phBe); end
    pushWord(32'h11223344, 1'b1);
    vectors++; if (busBe.inst_valid !== 1'b1 || busBe.inst_out !== 32'h11223344) begin miscompares++; $display("[TB] FAIL timeout_fresh_word: got valid=%b out=%h expected 1/11223344", busBe.inst_valid, busBe.inst_out); end
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_timeout_coincide();
    int pulses;
    pulses = 0;
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h02, 1'b1);
    applyStimulus(1'b1, 8'h03, 1'b1);
    for (int i = 1; i <= TMO - 1; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (toBe === 1'b1) pulses++;
    end
    vectors++; if (phBe !== 2'd3) begin miscompares++; $display("[TB] FAIL coincide_hold: got ph=%0d expected 3", phBe); end
    applyStimulus(1'b1, 8'h04, 1'b1);
    if (toBe === 1'b1) pulses++;
    vectors++; if (busBe.inst_valid !== 1'b1 || busBe.inst_out !== 32'h01020304) begin miscompares++; $display("[TB] FAIL coincide_word: got valid=%b out=%h expected 1/01020304", busBe.inst_valid, busBe.inst_out); end
    vectors++; if (wcBe !== 16'(mCount)) begin miscompares++; $display("[TB] FAIL coincide_count: got %0d expected %0d", wcBe, mCount); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    if (toBe === 1'b1) pulses++;
    vectors++; if (pulses != 0) begin miscompares++; $display("[TB] FAIL coincide_no_err: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_overflow();
    pulseReset();
    for (int k = 0; k <= DEPTH; k++) pushWord(32'(k), 1'b0);
    vectors++; if (ovBe !== 1'b1 || wcBe !== 16'd4) begin miscompares++; $display("[TB] FAIL ovf_flag_count: got ov=%b wc=%0d expected 1/4", ovBe, wcBe); end
    for (int k = 0; k < DEPTH; k++) begin
      vectors++; if (busBe.inst_valid !== 1'b1 || busBe.inst_out !== 32'(k)) begin miscompares++; $display("[TB] FAIL ovf_drain_%0d: got valid=%b out=%h expected 1/%h", k, busBe.inst_valid, busBe.inst_out, 32'(k)); end
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    vectors++; if (busBe.inst_valid !== 1'b0 || ovBe !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_empty: got valid=%b ov=%b expected 0/1", busBe.inst_valid, ovBe); end
  endtask

  task automatic test_full_pop();
    pulseReset();
    for (int k = 0; k < DEPTH; k++) pushWord(32'hA0 + 32'(k), 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b1);
    vectors++; if (ovBe !== 1'b0 || wcBe !== 16'd5) begin miscompares++; $display("[TB] FAIL fullpop_flags: got ov=%b wc=%0d expected 0/5", ovBe, wcBe); end
    for (int k = 1; k <= DEPTH; k++) begin
      vectors++; if (busBe.inst_valid !== 1'b1 || busBe.inst_out !== 32'hA0 + 32'(k)) begin miscompares++; $display("[TB] FAIL fullpop_drain_%0d: got valid=%b out=%h expected 1/%h", k, busBe.inst_valid, busBe.inst_out, 32'hA0 + 32'(k)); end
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    vectors++; if (busBe.inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fullpop_empty: got valid=%b expected 0", busBe.inst_valid); end
  endtask

  task automatic test_midreset();
    int pulses;
    pulses = 0;
    pulseReset();
    pushWord(32'hDEADBEEF, 1'b0);
    pushWord(32'hCAFEBABE, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    vectors++; if ({busBe.inst_valid, busBe.inst_out, wcBe, phBe, toBe, ovBe} !== 53'h0) begin miscompares++; $display("[TB] FAIL midreset_clear: got valid=%b out=%h wc=%0d ph=%0d to=%b ov=%b expected all 0", busBe.inst_valid, busBe.inst_out, wcBe, phBe, toBe, ovBe); end
    for (int i = 0; i < TMO + 2; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (toBe === 1'b1) pulses++;
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("[TB] FAIL midreset_no_err: got %0d pulses expected 0", pulses); end
    pushWord(32'h55667788, 1'b0);
    vectors++; if (busBe.inst_valid !== 1'b1 || busBe.inst_out !== 32'h55667788 || wcBe !== 16'd1) begin miscompares++; $display("[TB] FAIL midreset_word: got valid=%b out=%h wc=%0d expected 1/55667788/1", busBe.inst_valid, busBe.inst_out, wcBe); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    vectors++; if (busBe.inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_single: got valid=%b expected 0", busBe.inst_valid); end
  endtask

  task automatic test_random();
    int  gapLeft;
    bit  v;
    bit  rdy;
    int  errs;
    errs = 0;
    gapLeft = 0;
    pulseReset();
    for (int c = 0; c < 3000; c++) begin
      if (gapLeft == 0 && $urandom_range(0, 39) == 0) gapLeft = $urandom_range(TMO - 2, TMO + 2);
      if (gapLeft > 0) begin
        v = 1'b0;
        gapLeft--;
      end else begin
        v = ($urandom_range(0, 2) != 0);
      end
      rdy = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      applyStimulus(v, 8'($urandom), rdy);
      vectors++;
      if (busBe.inst_valid !== (mFifo.size() != 0) || wcBe !== 16'(mCount) || phBe !== 2'(mPartial.size()) ||
          toBe !== mTimeoutErr || ovBe !== mOverflow) begin
        miscompares++;
        if (errs < 10) $display("[TB] FAIL rand_status cyc %0d: got valid=%b wc=%0d ph=%0d to=%b ov=%b expected %b/%0d/%0d/%b/%b",
                                c, busBe.inst_valid, wcBe, phBe, toBe, ovBe, mFifo.size() != 0, mCount, mPartial.size(), mTimeoutErr, mOverflow);
        errs++;
      end
      if (mFifo.size() != 0) begin
        vectors++;
        if (busBe.inst_out !== mFifo[0]) begin
          miscompares++;
          if (errs < 10) $display("[TB] FAIL rand_data cyc %0d: got %h expected %h", c, busBe.inst_out, mFifo[0]);
          errs++;
        end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    mIdle = 0; mCount = 0; mOverflow = 1'b0; mTimeoutErr = 1'b0;
    reset = 1'b1;
    busBe.rx_valid = 1'b0; busBe.rx_data = 8'h00; busBe.inst_ready = 1'b0;
    test_reset();
    test_endianness();
    test_timeout();
    test_timeout_coincide();
    test_overflow();
    test_full_pop();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
